// File: rtl/led_pkg.sv
// Shared types and constants for the LED frame scheduler.
// This covers the strip size, colour type, owner ids and state encoding.
package led_pkg;

  localparam int NUM_LEDS = 300;
  localparam int POS_W    = 9;

  typedef logic [POS_W-1:0] pos_t;
  typedef logic [11:0]      color_t;
  typedef logic [2:0]       owner_t;

  localparam color_t BG_COLOR = 12'h000;
  localparam color_t WHITE    = 12'hFFF;

  localparam owner_t OWN_BG   = 3'd0;
  localparam owner_t OWN_BALL = 3'd1;
  localparam owner_t OWN_P1   = 3'd2;
  localparam owner_t OWN_P2   = 3'd3;
  localparam owner_t OWN_P3   = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_STREAM = 2'd2,
    ST_LATCH  = 2'd3
  } state_t;

endpackage

// File: rtl/led_frame_scheduler_owner_sel.sv
// Combinational per-LED ownership: ball beats player1 beats player2 beats player3.
// Paddle ranges are compared at 10 bits so they clip at the strip end instead of wrapping.
module pixel_owner_sel
  import led_pkg::*;
#(
  parameter int PADDLE_LEN = 3
) (
  input  pos_t   idx,
  input  pos_t   pos_ball,
  input  pos_t   pos_p1,
  input  pos_t   pos_p2,
  input  pos_t   pos_p3,
  input  color_t col_ball,
  input  color_t col_p1,
  input  color_t col_p2,
  input  color_t col_p3,
  output color_t color,
  output owner_t owner
);

  function automatic logic in_paddle(input pos_t i, input pos_t p);
    logic [9:0] lo;
    logic [9:0] hi;
    lo = {1'b0, p};
    hi = lo + 10'(PADDLE_LEN);
    return ({1'b0, i} >= lo) && ({1'b0, i} < hi);
  endfunction

  // Fixed-priority owner decode; positions past the strip never match an index.
  always_comb begin
    color = BG_COLOR;
    owner = OWN_BG;
    if (idx == pos_ball) begin
      color = col_ball;
      owner = OWN_BALL;
    end else if (in_paddle(idx, pos_p1)) begin
      color = col_p1;
      owner = OWN_P1;
    end else if (in_paddle(idx, pos_p2)) begin
      color = col_p2;
      owner = OWN_P2;
    end else if (in_paddle(idx, pos_p3)) begin
      color = col_p3;
      owner = OWN_P3;
    end else begin
      color = BG_COLOR;
      owner = OWN_BG;
    end
  end

endmodule

// File: rtl/led_frame_scheduler.sv
// Frame sequencer: snapshots sprites, streams one colour per LED over valid/ready,
// then holds a latch gap. One extra frame request can be queued while busy.
module led_frame_scheduler
  import led_pkg::*;
#(
  parameter int PADDLE_LEN   = 3,
  parameter int LATCH_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic [8:0]  ball,
  input  logic [8:0]  player1,
  input  logic [8:0]  player2,
  input  logic [8:0]  player3,
  input  logic [11:0] swb,
  input  logic [11:0] sw1,
  input  logic [11:0] sw2,
  input  logic [11:0] sw3,
  input  logic        pix_ready,
  output logic        pix_valid,
  output logic [11:0] pix_data,
  output logic [8:0]  pix_index,
  output logic        pix_last,
  output logic        busy,
  output logic        frame_done,
  output logic        overrun
);

  localparam pos_t       LAST_IDX  = pos_t'(NUM_LEDS - 1);
  localparam logic [7:0] LATCH_END = 8'(LATCH_CYCLES - 1);
  localparam logic [7:0] DONE_AT   = 8'(LATCH_CYCLES - 2);

  state_t     state_r, state_n_s;
  logic       pending_r, pending_n_s, overrun_n_s, frame_done_n_s;
  logic       pix_valid_r, pix_last_r, busy_r, frame_done_r, overrun_r;
  color_t     pix_data_r;
  pos_t       pix_index_r;
  logic [7:0] latch_cnt_r;
  pos_t       ball_r, p1_r, p2_r, p3_r;
  color_t     swb_r, sw1_r, sw2_r, sw3_r;
  pos_t       sel_idx_s, sel_ball_s, sel_p1_s, sel_p2_s, sel_p3_s;
  color_t     sel_cb_s, sel_c1_s, sel_c2_s, sel_c3_s, sel_color_s;
  owner_t     sel_owner_s;
  logic       xfer_s;

  assign xfer_s     = pix_valid_r && pix_ready;
  assign pix_valid  = pix_valid_r;
  assign pix_data   = pix_data_r;
  assign pix_index  = pix_index_r;
  assign pix_last   = pix_last_r;
  assign busy       = busy_r;
  assign frame_done = frame_done_r;
  assign overrun    = overrun_r;

  // The first pixel is produced in LOAD, so it reads the live inputs being snapshotted.
  always_comb begin
    if (state_r == ST_LOAD) begin
      sel_idx_s  = 9'd0;
      sel_ball_s = ball;    sel_p1_s = player1; sel_p2_s = player2; sel_p3_s = player3;
      sel_cb_s   = swb;     sel_c1_s = sw1;     sel_c2_s = sw2;     sel_c3_s = sw3;
    end else begin
      sel_idx_s  = pix_index_r + 9'd1;
      sel_ball_s = ball_r;  sel_p1_s = p1_r;    sel_p2_s = p2_r;    sel_p3_s = p3_r;
      sel_cb_s   = swb_r;   sel_c1_s = sw1_r;   sel_c2_s = sw2_r;   sel_c3_s = sw3_r;
    end
  end

  pixel_owner_sel #(.PADDLE_LEN(PADDLE_LEN)) u_owner_sel (
    .idx      (sel_idx_s),
    .pos_ball (sel_ball_s),
    .pos_p1   (sel_p1_s),
    .pos_p2   (sel_p2_s),
    .pos_p3   (sel_p3_s),
    .col_ball (sel_cb_s),
    .col_p1   (sel_c1_s),
    .col_p2   (sel_c2_s),
    .col_p3   (sel_c3_s),
    .color    (sel_color_s),
    .owner    (sel_owner_s)
  );

  // Next-state, pending-request and pulse decode.
  always_comb begin
    state_n_s      = state_r;
    pending_n_s    = pending_r;
    overrun_n_s    = 1'b0;
    frame_done_n_s = (state_r == ST_LATCH) && (latch_cnt_r == DONE_AT);
    case (state_r)
      ST_IDLE: begin
        if (frame_tick || pending_r) begin
          state_n_s = ST_LOAD;
        end else begin
          state_n_s = ST_IDLE;
        end
        // Starting consumes one request; a simultaneous tick stays queued.
        pending_n_s = pending_r && frame_tick;
      end
      ST_LOAD: begin
        state_n_s = ST_STREAM;
      end
      ST_STREAM: begin
        if (xfer_s && (pix_index_r == LAST_IDX)) begin
          state_n_s = ST_LATCH;
        end else begin
          state_n_s = ST_STREAM;
        end
      end
      ST_LATCH: begin
        if (latch_cnt_r == LATCH_END) begin
          state_n_s = ST_IDLE;
        end else begin
          state_n_s = ST_LATCH;
        end
      end
      default: begin
        state_n_s = ST_IDLE;
      end
    endcase
    if ((state_r != ST_IDLE) && frame_tick) begin
      overrun_n_s = pending_r;
      pending_n_s = 1'b1;
    end else begin
      overrun_n_s = 1'b0;
    end
  end

  // State, snapshot and pixel output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      pending_r    <= 1'b0;
      overrun_r    <= 1'b0;
      frame_done_r <= 1'b0;
      busy_r       <= 1'b0;
      pix_valid_r  <= 1'b0;
      pix_last_r   <= 1'b0;
      pix_data_r   <= 12'h000;
      pix_index_r  <= 9'd0;
      latch_cnt_r  <= 8'd0;
      ball_r <= 9'd0;   p1_r  <= 9'd0;    p2_r  <= 9'd0;    p3_r  <= 9'd0;
      swb_r  <= 12'h000; sw1_r <= 12'h000; sw2_r <= 12'h000; sw3_r <= 12'h000;
    end else begin
      state_r      <= state_n_s;
      pending_r    <= pending_n_s;
      overrun_r    <= overrun_n_s;
      frame_done_r <= frame_done_n_s;
      busy_r       <= (state_n_s != ST_IDLE);
      case (state_r)
        ST_LOAD: begin
          ball_r <= ball; p1_r  <= player1; p2_r  <= player2; p3_r  <= player3;
          swb_r  <= swb;  sw1_r <= sw1;     sw2_r <= sw2;     sw3_r <= sw3;
          pix_valid_r <= 1'b1;
          pix_index_r <= 9'd0;
          pix_data_r  <= (sel_owner_s == OWN_BG) ? BG_COLOR : sel_color_s;
          pix_last_r  <= (LAST_IDX == 9'd0);
        end
        ST_STREAM: begin
          if (xfer_s && (pix_index_r == LAST_IDX)) begin
            pix_valid_r <= 1'b0;
            pix_last_r  <= 1'b0;
            latch_cnt_r <= 8'd0;
          end else if (xfer_s) begin
            pix_index_r <= sel_idx_s;
            pix_data_r  <= (sel_owner_s == OWN_BG) ? BG_COLOR : sel_color_s;
            pix_last_r  <= (sel_idx_s == LAST_IDX);
          end else begin
            pix_index_r <= pix_index_r;
          end
        end
        ST_LATCH: begin
          latch_cnt_r <= latch_cnt_r + 8'd1;
        end
        default: begin
          latch_cnt_r <= latch_cnt_r;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led_frame_scheduler.sv
// Directed bench for led_frame_scheduler: full frames, priority, clipping,
// backpressure, queued ticks with overrun, and mid-frame reset.
module tb_led_frame_scheduler;

  logic        clk = 1'b0;
  logic        reset, frame_tick, pix_ready;
  logic [8:0]  ball, player1, player2, player3;
  logic [11:0] swb, sw1, sw2, sw3;
  logic        pix_valid, pix_last, busy, frame_done, overrun;
  logic [11:0] pix_data;
  logic [8:0]  pix_index;

  int tests_run = 0;
  int tests_failed = 0;
  int ov_cnt = 0;
  int m_b, m_p1, m_p2, m_p3;
  logic [11:0] m_cb, m_c1, m_c2, m_c3;

  led_frame_scheduler dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick),
    .ball(ball), .player1(player1), .player2(player2), .player3(player3),
    .swb(swb), .sw1(sw1), .sw2(sw2), .sw3(sw3),
    .pix_ready(pix_ready), .pix_valid(pix_valid), .pix_data(pix_data),
    .pix_index(pix_index), .pix_last(pix_last), .busy(busy),
    .frame_done(frame_done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (overrun) ov_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] model_color(input int i);
    if (i == m_b) return m_cb;
    else if (i >= m_p1 && i < m_p1 + 3) return m_c1;
    else if (i >= m_p2 && i < m_p2 + 3) return m_c2;
    else if (i >= m_p3 && i < m_p3 + 3) return m_c3;
    else return 12'h000;
  endfunction

  task automatic set_sprites(input int b, input int p1, input int p2, input int p3);
    ball = 9'(b); player1 = 9'(p1); player2 = 9'(p2); player3 = 9'(p3);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_valid"}, pix_valid, 0);
    check({tag, "_data"},  pix_data, 0);
    check({tag, "_index"}, pix_index, 0);
    check({tag, "_last"},  pix_last, 0);
    check({tag, "_busy"},  busy, 0);
    check({tag, "_done"},  frame_done, 0);
    check({tag, "_ovr"},   overrun, 0);
  endtask

  // Pulses a tick in an idle cycle and checks the two-cycle latency to the first pixel.
  task automatic start_frame(input string tag);
    m_b = int'(ball); m_p1 = int'(player1); m_p2 = int'(player2); m_p3 = int'(player3);
    m_cb = swb; m_c1 = sw1; m_c2 = sw2; m_c3 = sw3;
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    check({tag, "_load_valid"}, pix_valid, 0);
    check({tag, "_load_busy"}, busy, 1);
    @(negedge clk);
    check({tag, "_first_valid"}, pix_valid, 1);
    check({tag, "_first_index"}, pix_index, 0);
  endtask

  task automatic stream_frame(input string tag, input int mode, input int tick_a,
                              input int tick_b, input int abort_at, input int move_at);
    int exp_idx = 0, n_xfer = 0, cycles = 0, low_run = 0, done_k = 0, cur = 0;
    int bad_idx = 0, bad_data = 0, bad_last = 0, bad_stall = 0;
    logic stalled = 1'b0;
    logic [11:0] pd = 12'h000;
    logic [8:0] pi = 9'd0;
    logic pl = 1'b0;
    bit finished = 1'b0, aborted = 1'b0;
    while (!finished && cycles < 4000) begin
      frame_tick = 1'b0;
      if (stalled && (!pix_valid || pix_data !== pd || pix_index !== pi || pix_last !== pl))
        bad_stall++;
      if (mode == 0) begin
        pix_ready = 1'b1;
      end else if (low_run >= 5) begin
        pix_ready = 1'b1;
        low_run = 0;
      end else begin
        pix_ready = ($urandom_range(0, 1) == 1);
        if (!pix_ready) low_run++; else low_run = 0;
      end
      cur = int'(pix_index);
      if (pix_valid && cur == abort_at) begin
        reset = 1'b1;
        aborted = 1'b1;
        finished = 1'b1;
      end else if (pix_valid && pix_ready) begin
        if (cur != exp_idx) bad_idx++;
        if (pix_data !== model_color(cur)) bad_data++;
        if (pix_last !== (cur == 299)) bad_last++;
        if (cur == tick_a || cur == tick_b) frame_tick = 1'b1;
        if (cur == move_at) ball = 9'd200;
        if (cur == 299) finished = 1'b1;
        exp_idx = cur + 1;
        n_xfer++;
      end
      stalled = pix_valid && !pix_ready;
      pd = pix_data; pi = pix_index; pl = pix_last;
      @(negedge clk);
      cycles++;
    end
    frame_tick = 1'b0;
    pix_ready = 1'b1;
    check({tag, "_xfers"}, n_xfer, aborted ? 120 : 300);
    check({tag, "_index_seq"}, bad_idx, 0);
    check({tag, "_data"}, bad_data, 0);
    check({tag, "_last"}, bad_last, 0);
    check({tag, "_stall_hold"}, bad_stall, 0);
    if (!aborted) begin
      check({tag, "_valid_drop"}, pix_valid, 0);
      check({tag, "_last_drop"}, pix_last, 0);
      if (mode == 0) check({tag, "_cycles"}, cycles, 300);
      done_k = 1;
      while (!frame_done && done_k < 40) begin
        @(negedge clk);
        done_k++;
      end
      check({tag, "_done_gap"}, done_k, 16);
      @(negedge clk);
      check({tag, "_done_pulse"}, frame_done, 0);
      check({tag, "_idle_busy"}, busy, 0);
    end
  endtask

  initial begin
    int base, wait_k;
    reset = 1'b1; frame_tick = 1'b0; pix_ready = 1'b1;
    set_sprites(10, 29, 59, 89);
    swb = 12'hA01; sw1 = 12'hB02; sw2 = 12'hC03; sw3 = 12'hD04;
    repeat (3) @(negedge clk);
    check_idle("reset");
    reset = 1'b0;
    @(negedge clk);
    check_idle("idle");

    start_frame("basic");
    stream_frame("basic", 0, -1, -1, -1, -1);

    set_sprites(30, 29, 100, 200);
    start_frame("prio");
    stream_frame("prio", 0, -1, -1, -1, -1);

    set_sprites(511, 150, 300, 298);
    start_frame("clip");
    stream_frame("clip", 0, -1, -1, -1, -1);

    set_sprites(10, 29, 59, 89);
    start_frame("bp");
    stream_frame("bp", 1, -1, -1, -1, 150);

    set_sprites(10, 29, 59, 89);
    base = ov_cnt;
    start_frame("ovr");
    stream_frame("ovr", 0, 50, 100, -1, -1);
    check("ovr_count", ov_cnt - base, 1);
    wait_k = 0;
    while (!pix_valid && wait_k < 8) begin
      @(negedge clk);
      wait_k++;
    end
    check("auto_start", pix_valid, 1);
    check("auto_index", pix_index, 0);
    stream_frame("auto", 0, -1, -1, -1, -1);
    check("auto_no_ovr", ov_cnt - base, 1);

    start_frame("abort");
    stream_frame("abort", 0, -1, -1, 120, -1);
    check_idle("abort");
    reset = 1'b0;
    @(negedge clk);
    start_frame("restart");
    stream_frame("restart", 0, -1, -1, -1, -1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
